// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion: one 32-bit word per clock through a single SubWord
// datapath, with round keys held in a word store that can be read by round index.
module aes_key_schedule #(
  parameter bit ENABLE_192 = 1'b1,
  parameter bit ENABLE_256 = 1'b1,
  parameter bit RD_ZERO    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  output logic         busy,
  output logic         key_ready,
  output logic         err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic [1:0]   dbg_state
);

  // Handshake: start is a one-cycle request sampled on a rising edge. It is taken
  // only while busy=0 (IDLE/READY); while busy=1 it is silently dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2} state_t;

  localparam int DEPTH = ENABLE_256 ? 60 : (ENABLE_192 ? 52 : 44);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t      state;
  logic [3:0]  nk;
  logic [5:0]  i_cnt;
  logic [5:0]  last_idx;
  logic [2:0]  kmod;
  logic [7:0]  rcon;
  logic [31:0] w_mem [DEPTH];

  logic        len_ok;
  logic [3:0]  nk_new;
  logic        accept;
  logic        reject;
  logic [31:0] prev_w;
  logic [31:0] back_w;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_w;
  logic [5:0]  rd_base;

  always_comb begin
    len_ok = 1'b0;
    nk_new = 4'd4;
    case (key_len)
      2'b00: begin len_ok = 1'b1;       nk_new = 4'd4; end
      2'b01: begin len_ok = ENABLE_192; nk_new = 4'd6; end
      2'b10: begin len_ok = ENABLE_256; nk_new = 4'd8; end
      default: ;
    endcase
  end

  assign accept = start && (state != EXPAND) && len_ok;
  assign reject = start && (state != EXPAND) && !len_ok;

  assign prev_w  = w_mem[i_cnt - 6'd1];
  assign back_w  = w_mem[i_cnt - {2'b00, nk}];
  assign sub_in  = (kmod == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign sub_out = sub_word(sub_in);

  always_comb begin
    temp = prev_w;
    if (kmod == 3'd0)                     temp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kmod == 3'd4)  temp = sub_out;
  end

  assign new_w     = back_w ^ temp;
  assign rd_base   = {rd_round, 2'b00};
  assign dbg_state = state;

  // Word store carries no reset; contents only matter once key_ready is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int k = 0; k < 8; k++)
          if (k < int'(nk_new)) w_mem[6'(k)] <= key[255 - 32*k -: 32];
      end else if (state == EXPAND) begin
        w_mem[i_cnt] <= new_w;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      nk         <= 4'd4;
      i_cnt      <= 6'd0;
      last_idx   <= 6'd0;
      kmod       <= 3'd0;
      rcon       <= 8'h01;
      busy       <= 1'b0;
      key_ready  <= 1'b0;
      err        <= 1'b0;
      num_rounds <= 4'd0;
      rd_key     <= '0;
    end else begin
      err <= reject;
      case (state)
        IDLE, READY: begin
          if (accept) begin
            nk         <= nk_new;
            i_cnt      <= {2'b00, nk_new};
            last_idx   <= {nk_new, 2'b00} + 6'd27;
            kmod       <= 3'd0;
            rcon       <= 8'h01;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            num_rounds <= nk_new + 4'd6;
            state      <= EXPAND;
          end
        end
        EXPAND: begin
          i_cnt <= i_cnt + 6'd1;
          kmod  <= ({1'b0, kmod} == nk - 4'd1) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i_cnt == last_idx) begin
            busy      <= 1'b0;
            key_ready <= 1'b1;
            state     <= READY;
          end
        end
        default: state <= IDLE;
      endcase
      if (key_ready && rd_round <= num_rounds)
        rd_key <= {w_mem[rd_base], w_mem[rd_base + 6'd1], w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
      else if (RD_ZERO)
        rd_key <= '0;
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 appendix A key expansions.
module tb_aes_key_schedule;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start2;
  logic [1:0]   key_len, key_len2;
  logic [255:0] key;
  logic [3:0]   rd_round;
  logic         busy, key_ready, err, busy2, key_ready2, err2;
  logic [3:0]   num_rounds, num_rounds2;
  logic [127:0] rd_key, rd_key2;
  logic [1:0]   dbg_state, dbg_state2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .key_ready(key_ready), .err(err), .num_rounds(num_rounds),
    .rd_round(rd_round), .rd_key(rd_key), .dbg_state(dbg_state)
  );

  aes_key_schedule #(.ENABLE_256(1'b0)) dut_no256 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len2), .key(key),
    .busy(busy2), .key_ready(key_ready2), .err(err2), .num_rounds(num_rounds2),
    .rd_round(rd_round), .rd_key(rd_key2), .dbg_state(dbg_state2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [1:0] len, input logic [255:0] k);
    key_len = len;
    key     = k;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!key_ready && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic read_round(input logic [3:0] r, output logic [127:0] v);
    rd_round = r;
    tick();
    v = rd_key;
  endtask

  initial begin
    int           cyc;
    bit           saw_err;
    logic [127:0] v;

    rst = 1'b1; start = 1'b0; start2 = 1'b0; key_len = 2'b00; key_len2 = 2'b00;
    key = '0; rd_round = 4'd0;
    tick(); tick();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_key_ready", 128'(key_ready), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_num_rounds", 128'(num_rounds), 128'd0);
    check("rst_rd_key", rd_key, 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    rst = 1'b0;
    read_round(4'd3, v);
    check("idle_read_zero", v, 128'd0);

    // AES-128
    start_key(2'b00, K128);
    check("a1_busy", 128'(busy), 128'd1);
    check("a1_num_rounds", 128'(num_rounds), 128'd10);
    wait_ready(cyc);
    check("a1_ready_cycles", 128'(cyc), 128'd40);
    check("a1_busy_done", 128'(busy), 128'd0);
    read_round(4'd0, v);
    check("a1_round0", v, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_round(4'd1, v);
    check("a1_round1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_round = 4'd10;
    #2;
    check("a1_latency_hold", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
    tick();
    check("a1_round10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_round(4'd11, v);
    check("a1_round11_zero", v, 128'd0);

    // Illegal key length keeps the held schedule
    start_key(2'b11, K256);
    check("ill_err", 128'(err), 128'd1);
    check("ill_busy", 128'(busy), 128'd0);
    check("ill_key_ready", 128'(key_ready), 128'd1);
    tick();
    check("ill_err_pulse", 128'(err), 128'd0);
    read_round(4'd10, v);
    check("ill_round10_kept", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Build without 256-bit support
    key_len2 = 2'b10; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("no256_err", 128'(err2), 128'd1);
    check("no256_busy", 128'(busy2), 128'd0);
    key_len2 = 2'b01; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("no256_192_busy", 128'(busy2), 128'd1);
    check("no256_192_rounds", 128'(num_rounds2), 128'd12);

    // AES-192, with a read held on round 3 across the restart
    read_round(4'd3, v);
    check("a1_round3_nonzero", 128'(v != 128'd0), 128'd1);
    start_key(2'b01, K192);
    check("a2_key_ready_drop", 128'(key_ready), 128'd0);
    tick();
    check("a2_busy_read_zero", rd_key, 128'd0);
    wait_ready(cyc);
    check("a2_ready_cycles", 128'(cyc + 1), 128'd46);
    check("a2_num_rounds", 128'(num_rounds), 128'd12);
    read_round(4'd0, v);
    check("a2_round0", v, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_round(4'd1, v);
    check("a2_round1", v, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_round(4'd12, v);
    check("a2_round12", v, 128'he98ba06f448c773c8ecc720401002202);

    // AES-256, with a second start while busy
    start_key(2'b10, K256);
    cyc = 0;
    saw_err = 1'b0;
    while (!key_ready && cyc < 200) begin
      if (cyc == 5) begin
        key_len = 2'b00;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
      if (err) saw_err = 1'b1;
    end
    check("a3_ready_cycles", 128'(cyc), 128'd52);
    check("a3_busy_start_no_err", 128'(saw_err), 128'd0);
    check("a3_num_rounds", 128'(num_rounds), 128'd14);
    read_round(4'd0, v);
    check("a3_round0", v, 128'h603deb1015ca71be2b73aef0857d7781);
    read_round(4'd2, v);
    check("a3_round2", v, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_round(4'd3, v);
    check("a3_round3", v, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    read_round(4'd14, v);
    check("a3_round14", v, 128'hfe4890d1e6188d0b046df344706c631e);

    // Asynchronous reset in the middle of an expansion
    start_key(2'b00, K128);
    repeat (20) tick();
    check("mid_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_key_ready", 128'(key_ready), 128'd0);
    check("mid_rst_rd_key", rd_key, 128'd0);
    check("mid_rst_num_rounds", 128'(num_rounds), 128'd0);
    tick();
    rst = 1'b0;
    start_key(2'b00, K128);
    wait_ready(cyc);
    check("rerun_ready_cycles", 128'(cyc), 128'd40);
    read_round(4'd10, v);
    check("rerun_round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
